// File: rtl/updown_mod_counter.sv
// Up/down counter with a programmable modulus, parallel load, and wrap or saturate at the bounds.
// The wrap pulse is registered. tc is decoded from y and updown so that stages can be cascaded.
module updown_mod_counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter bit SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             updown,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] y,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

    logic [WIDTH-1:0] r_y;
    logic             r_wrap;
    logic [WIDTH-1:0] w_y_next;
    logic             w_wrap_next;
    logic [WIDTH-1:0] w_load_clamped;
    logic             w_at_max;
    logic             w_at_zero;

    // Values above the modulus are clamped on load, so y never leaves 0..MAX_COUNT.
    always_comb begin
        w_at_max  = (r_y == MAX_V);
        w_at_zero = (r_y == ZERO_V);
        if (load_val > MAX_V) begin
            w_load_clamped = MAX_V;
        end else begin
            w_load_clamped = load_val;
        end
    end

    // Next-state logic. Load has priority over count; a bound event sets the wrap pulse.
    always_comb begin
        w_y_next    = r_y;
        w_wrap_next = 1'b0;
        if (load) begin
            w_y_next = w_load_clamped;
        end else if (en) begin
            if (updown) begin
                if (w_at_max) begin
                    w_wrap_next = 1'b1;
                    if (SATURATE) begin
                        w_y_next = r_y;
                    end else begin
                        w_y_next = ZERO_V;
                    end
                end else begin
                    w_y_next = r_y + ONE_V;
                end
            end else begin
                if (w_at_zero) begin
                    w_wrap_next = 1'b1;
                    if (SATURATE) begin
                        w_y_next = r_y;
                    end else begin
                        w_y_next = MAX_V;
                    end
                end else begin
                    w_y_next = r_y - ONE_V;
                end
            end
        end else begin
            w_y_next = r_y;
        end
    end

    // Count and wrap-pulse registers. Reset aborts any pending load or count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y    <= ZERO_V;
            r_wrap <= 1'b0;
        end else begin
            r_y    <= w_y_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign y    = r_y;
    assign wrap = r_wrap;
    assign tc   = updown ? w_at_max : w_at_zero;

endmodule
